game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Round/state controller for the VGA game datapath. Debounces the start and pause buttons and
//  gates the game-logic block with run/clear controls. Runs countdown -> play -> pause/over
//  sequencing from frame ticks, and tracks lives and round time.
//  Selects the 16-bit value shown on the seven-segment counter.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  clk cycles a synced button must be stable before it is accepted
//  FRAMES_PER_SEC   60         frame_tick pulses per game second
//  COUNTDOWN_SECS   3          seconds spent in COUNTDOWN before PLAY
//  ROUND_SECS       60         round length in seconds (<=255)
//  START_LIVES      3          lives loaded at round start (1..3)
// PORTS
//  clk            in   1   system clock (100 MHz)
//  reset_n        in   1   asynchronous active-low reset
//  btn_start      in   1   raw start button (asynchronous)
//  btn_pause      in   1   raw pause button (asynchronous)
//  frame_tick     in   1   1-cycle pulse once per frame (vertical wrap)
//  hit            in   1   1-cycle pulse from game logic: player lost a life
//  score          in   16  current score from game logic
//  run            out  1   datapath advance enable (high only in PLAY)
//  clear          out  1   1-cycle pulse: game logic resets score/positions
//  state          out  3   0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 OVER
//  lives          out  2   remaining lives
//  time_left      out  8   remaining round seconds
//  display_number out  16  value routed to seven-segment counter
//  high_score     out  16  best score since reset
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, run=0, clear=0, lives=START_LIVES, time_left=ROUND_SECS,
//   high_score=0, debouncers cleared to released, all counters 0.
//  Buttons: 2-flop sync, then stability counter; accepted level changes after DEBOUNCE_CYCLES
//   stable cycles. start_p/pause_p = 1-cycle pulse on accepted rising edge.
//   Button-to-action latency = 2 sync + DEBOUNCE_CYCLES + 1 cycles.
//  Frame counter fcnt counts frame_tick 0..FRAMES_PER_SEC-1; sec_p fires on wrap.
//   fcnt clears on every state change.
//  Transitions (registered, one per cycle):
//   IDLE/OVER --start_p--> COUNTDOWN; same cycle: clear=1, lives=START_LIVES, time_left=ROUND_SECS.
//   COUNTDOWN: counts COUNTDOWN_SECS sec_p, then -> PLAY. start_p/pause_p ignored.
//   PLAY: run=1 combinationally from state. sec_p decrements time_left. hit decrements lives.
//     lives reaching 0 or time_left reaching 0 -> OVER. pause_p -> PAUSE.
//   PAUSE: frame counting frozen, hit ignored; pause_p or start_p -> PLAY.
//  Simultaneous events in PLAY, by priority: game over (hit with lives==1, or sec_p with
//   time_left==1) > pause_p. hit and sec_p in the same cycle both apply.
//  Saturation: lives and time_left never wrap below 0. hit is ignored outside PLAY.
//  display_number: COUNTDOWN shows remaining countdown secs. PLAY/PAUSE show score.
//   IDLE/OVER show score (see macro). Registered, 1-cycle latency.
//  Reset mid-round returns to IDLE immediately. The next start_p pulses clear.
// CONFIGURATION
//  HIGH_SCORE_EN defined:
//   - On entry to OVER, high_score <= max(high_score, score).
//   - In IDLE/OVER, display_number alternates every 2 s between score and high_score
//     (fcnt keeps running).
//  Undefined:
//   - high_score tied to 16'h0000.
//   - IDLE/OVER show score only; no alternation logic is generated.
// TESTING
//  Bench params for all scenarios: DEBOUNCE_CYCLES=4, FRAMES_PER_SEC=2, COUNTDOWN_SECS=1,
//   ROUND_SECS=3, START_LIVES=2.
//  1 Press start for 10 cycles -> clear pulses exactly 1 cycle; state=1; after 2 frame_ticks
//    state=2 and run=1.
//  2 Glitch: btn_start high for 3 cycles -> no start_p; state stays IDLE.
//  3 In PLAY, 6 frame_ticks -> time_left 3->2->1->0; state=OVER; run=0; lives=2.
//  4 In PLAY, hit twice -> lives 2->1->0 and state=OVER. A 3rd hit leaves lives=0.
//  5 In PLAY, press pause -> state=PAUSE; 4 frame_ticks leave time_left unchanged;
//    press pause -> PLAY.
//  6 HIGH_SCORE_EN on: end round with score=0x0123 -> high_score=0x0123. Next round ends with
//    score=0x0042 -> high_score stays 0x0123. Drop reset_n mid-PLAY -> state=0, high_score=0.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: round/state controller for the VGA game datapath.
//  Debounces start/pause buttons, sequences IDLE -> COUNTDOWN -> PLAY -> PAUSE/OVER
//  from frame ticks, tracks lives and round time, and selects the seven-segment value.
// Optional feature macro: HIGH_SCORE_EN (high-score tracking and IDLE/OVER display alternation).
// Ports:
//  clk, reset_n          clock, asynchronous active-low reset
//  btn_start, btn_pause  raw asynchronous buttons
//  frame_tick            1-cycle pulse per frame
//  hit                   1-cycle pulse: player lost a life
//  score[15:0]           current score from game logic
//  run                   datapath advance enable (decoded from state)
//  clear                 1-cycle pulse resetting game logic at round start
//  state[2:0]            0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 OVER
//  lives[1:0]            remaining lives
//  time_left[7:0]        remaining round seconds
//  display_number[15:0]  value routed to seven-segment counter
//  high_score[15:0]      best score since reset (0 when feature disabled)
module game_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned FRAMES_PER_SEC  = 60,
  parameter int unsigned COUNTDOWN_SECS  = 3,
  parameter int unsigned ROUND_SECS      = 60,
  parameter int unsigned START_LIVES     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic [15:0] score,
  output logic        run,
  output logic        clear,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic [7:0]  time_left,
  output logic [15:0] display_number,
  output logic [15:0] high_score
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int unsigned CD_W = $clog2(COUNTDOWN_SECS + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_OVER      = 3'd4
  } state_e;

  // Button conditioning: bit 0 = start, bit 1 = pause
  logic [1:0]      sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic            start_p, pause_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q    <= {btn_pause, btn_start};
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int b = 0; b < 2; b++) begin
        // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
        if (sync2_q[b] == deb_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[b]    <= sync2_q[b];
          db_cnt_q[b] <= '0;
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  assign start_p = deb_q[0] & ~deb_prev_q[0];
  assign pause_p = deb_q[1] & ~deb_prev_q[1];

  // Sequencer registers
  state_e          state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [1:0]      lives_q, lives_d;
  logic [7:0]      time_q, time_d;
  logic            clear_q, clear_d;
  logic [15:0]     disp_q, disp_d;
  logic            sec_p;

`ifdef HIGH_SCORE_EN
  logic [15:0] hs_q, hs_d;
  logic        alt_sec_q, alt_sec_d;
  logic        show_hs_q, show_hs_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      fcnt_q    <= '0;
      cd_q      <= '0;
      lives_q   <= 2'(START_LIVES);
      time_q    <= 8'(ROUND_SECS);
      clear_q   <= 1'b0;
      disp_q    <= '0;
`ifdef HIGH_SCORE_EN
      hs_q      <= '0;
      alt_sec_q <= 1'b0;
      show_hs_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      cd_q      <= cd_d;
      lives_q   <= lives_d;
      time_q    <= time_d;
      clear_q   <= clear_d;
      disp_q    <= disp_d;
`ifdef HIGH_SCORE_EN
      hs_q      <= hs_d;
      alt_sec_q <= alt_sec_d;
      show_hs_q <= show_hs_d;
`endif
    end
  end

  // Frame counting is frozen while paused
  assign sec_p = frame_tick && (state_q != S_PAUSE) && (fcnt_q == FC_W'(FRAMES_PER_SEC - 1));

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    cd_d    = cd_q;
    lives_d = lives_q;
    time_d  = time_q;
    clear_d = 1'b0;
    disp_d  = score;
`ifdef HIGH_SCORE_EN
    hs_d      = hs_q;
    alt_sec_d = alt_sec_q;
    show_hs_d = show_hs_q;
`endif

    if (frame_tick && (state_q != S_PAUSE)) begin
      fcnt_d = sec_p ? '0 : fcnt_q + FC_W'(1);
    end

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_p) begin
          state_d = S_COUNTDOWN;
          clear_d = 1'b1;
          lives_d = 2'(START_LIVES);
          time_d  = 8'(ROUND_SECS);
          cd_d    = '0;
        end
`ifdef HIGH_SCORE_EN
        if (sec_p) begin
          alt_sec_d = ~alt_sec_q;
          if (alt_sec_q) show_hs_d = ~show_hs_q;
        end
`endif
      end
      S_COUNTDOWN: begin
        if (sec_p) begin
          if (cd_q == CD_W'(COUNTDOWN_SECS - 1)) state_d = S_PLAY;
          else                                    cd_d    = cd_q + CD_W'(1);
        end
      end
      S_PLAY: begin
        if (hit && (lives_q != 2'd0))  lives_d = lives_q - 2'd1;
        if (sec_p && (time_q != 8'd0)) time_d  = time_q - 8'd1;
        // Game over outranks a simultaneous pause request
        if ((hit && (lives_q == 2'd1)) || (sec_p && (time_q == 8'd1))) state_d = S_OVER;
        else if (pause_p)                                              state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause_p || start_p) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      fcnt_d = '0;
`ifdef HIGH_SCORE_EN
      alt_sec_d = 1'b0;
      show_hs_d = 1'b0;
`endif
    end

`ifdef HIGH_SCORE_EN
    if ((state_d == S_OVER) && (state_q != S_OVER) && (score > hs_q)) hs_d = score;
`endif

    // Display selection, registered for one cycle of latency
    case (state_q)
      S_COUNTDOWN: disp_d = 16'(COUNTDOWN_SECS) - 16'(cd_q);
`ifdef HIGH_SCORE_EN
      S_IDLE, S_OVER: disp_d = show_hs_q ? hs_q : score;
`endif
      default: disp_d = score;
    endcase
  end

  assign run            = (state_q == S_PLAY);
  assign clear          = clear_q;
  assign state          = state_q;
  assign lives          = lives_q;
  assign time_left      = time_q;
  assign display_number = disp_q;
`ifdef HIGH_SCORE_EN
  assign high_score     = hs_q;
`else
  assign high_score     = 16'h0000;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer with small timing parameters.
module tb_game_sequencer;

`ifdef HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, btn_start, btn_pause, frame_tick, hit;
  logic [15:0] score;
  logic        run, clear;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [7:0]  time_left;
  logic [15:0] display_number, high_score;

  int n_checks = 0;
  int n_errors = 0;
  int clr_cnt  = 0;

  typedef struct {
    string       kind;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  game_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .FRAMES_PER_SEC (2),
    .COUNTDOWN_SECS (1),
    .ROUND_SECS     (3),
    .START_LIVES    (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_start     (btn_start),
    .btn_pause     (btn_pause),
    .frame_tick    (frame_tick),
    .hit           (hit),
    .score         (score),
    .run           (run),
    .clear         (clear),
    .state         (state),
    .lives         (lives),
    .time_left     (time_left),
    .display_number(display_number),
    .high_score    (high_score)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sample(input string k);
    case (k)
      "state": return 32'(state);
      "run":   return 32'(run);
      "clear": return 32'(clear);
      "lives": return 32'(lives);
      "time":  return 32'(time_left);
      "disp":  return 32'(display_number);
      "hs":    return 32'(high_score);
      "clr_n": return 32'(clr_cnt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drain(input string step);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({step, ".", e.kind}, sample(e.kind), e.val);
    end
  endtask

  // Hold a button 10 cycles, then let the release settle; counts clear pulses seen
  task automatic press(input bit use_pause);
    clr_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (clear) clr_cnt++;
      btn_start = !use_pause && (i < 10);
      btn_pause = use_pause && (i < 10);
    end
    btn_start = 1'b0;
    btn_pause = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic hit_pulse();
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Start from IDLE/OVER and run the countdown into PLAY
  task automatic start_round(input string step);
    press(1'b0);
    push("clr_n", 1); push("state", 1); push("lives", 2); push("time", 3); push("disp", 1);
    drain({step, ".cd"});
    tick();
    push("state", 1);
    drain({step, ".cd1"});
    tick();
    push("state", 2); push("run", 1);
    drain({step, ".play"});
  endtask

  initial begin
    reset_n = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    frame_tick = 1'b0; hit = 1'b0; score = 16'h0000;
    repeat (3) @(negedge clk);
    push("state", 0); push("run", 0); push("clear", 0); push("lives", 2);
    push("time", 3); push("hs", 0); push("disp", 0);
    drain("reset");
    reset_n = 1'b1;

    // Short glitch must not be accepted
    @(negedge clk) btn_start = 1'b1;
    repeat (3) @(negedge clk);
    btn_start = 1'b0;
    repeat (20) @(negedge clk);
    push("state", 0); push("clear", 0);
    drain("glitch");

    // Round 1: time runs out
    start_round("r1");
    score = 16'h0123;
    for (int s = 2; s >= 0; s--) begin
      tick();
      tick();
      push("time", 32'(s));
      push("state", (s == 0) ? 32'd4 : 32'd2);
      drain("r1.sec");
    end
    push("run", 0); push("lives", 2); push("disp", 32'h0123);
    push("hs", HS_EN ? 32'h0123 : 32'h0);
    drain("r1.over");

    // Round 2: lives run out, extra hit saturates
    start_round("r2");
    score = 16'h0042;
    hit_pulse();
    push("lives", 1); push("state", 2);
    drain("r2.hit1");
    hit_pulse();
    push("lives", 0); push("state", 4); push("run", 0);
    drain("r2.hit2");
    hit_pulse();
    push("lives", 0); push("state", 4);
    push("hs", HS_EN ? 32'h0123 : 32'h0);
    drain("r2.hit3");

    // Round 3: pause freezes time
    start_round("r3");
    press(1'b1);
    push("state", 3); push("run", 0); push("disp", 32'h0042);
    drain("r3.pause");
    repeat (4) tick();
    push("time", 3); push("state", 3);
    drain("r3.frozen");
    press(1'b1);
    push("state", 2); push("time", 3);
    drain("r3.resume");
    tick();
    tick();
    push("time", 2);
    drain("r3.sec");

    // Reset mid-PLAY
    do_reset();
    push("state", 0); push("hs", 0); push("lives", 2); push("time", 3); push("run", 0);
    drain("midrst");
    reset_n = 1'b1;
    start_round("r4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always ends on its own
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
